// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the two-requester ALU arbiter.
package alu_arb_pkg;

    localparam int W_DEF       = 4;
    localparam int NUM_OPS_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op, input int num_ops = NUM_OPS_DEF);
        return (int'(op) < num_ops);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that was not served last wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = valid0 && (!valid1 || last_grant);
        gnt1 = valid1 && (!valid0 || !last_grant);
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters: accept, evaluate for one cycle, hold response.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int NUM_OPS = NUM_OPS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s0_valid,
    output logic         s0_ready,
    input  logic [W-1:0] s0_a,
    input  logic [W-1:0] s0_b,
    input  logic [2:0]   s0_op,
    input  logic         s1_valid,
    output logic         s1_ready,
    input  logic [W-1:0] s1_a,
    input  logic [W-1:0] s1_b,
    input  logic [2:0]   s1_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_c,
    input  logic         alu_co,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_c,
    output logic         rsp_co,
    output logic         rsp_err,
    output logic         busy
);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q, rsp_c_q;
    logic [2:0]     op_q;
    logic           id_q, rsp_co_q, err_q, last_grant_q;
    logic           gnt0, gnt1;
    logic           accept, acc_id, acc_legal;
    logic [W-1:0]   acc_a, acc_b;
    logic [2:0]     acc_op;

    rr_arb2 u_rr (
        .valid0     (s0_valid),
        .valid1     (s1_valid),
        .last_grant (last_grant_q),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    // Ready is withheld while reset is asserted even though state already reads IDLE.
    assign s0_ready  = !rst && (state_q == IDLE) && gnt0;
    assign s1_ready  = !rst && (state_q == IDLE) && gnt1;
    assign accept    = s0_ready || s1_ready;
    assign acc_id    = s1_ready;
    assign acc_a     = acc_id ? s1_a  : s0_a;
    assign acc_b     = acc_id ? s1_b  : s0_b;
    assign acc_op    = acc_id ? s1_op : s0_op;
    assign acc_legal = op_legal(acc_op, NUM_OPS);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = acc_legal ? EXEC : RESP;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand registers load only for legal ops, so an illegal opcode never reaches the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_c_q      <= '0;
            rsp_co_q     <= 1'b0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q <= acc_id;
                if (acc_legal) begin
                    a_q  <= acc_a;
                    b_q  <= acc_b;
                    op_q <= acc_op;
                end else begin
                    err_q    <= 1'b1;
                    rsp_c_q  <= '0;
                    rsp_co_q <= 1'b0;
                end
            end
            if (state_q == EXEC) begin
                rsp_c_q  <= alu_c;
                rsp_co_q <= alu_co;
                err_q    <= 1'b0;
            end
            if ((state_q == RESP) && rsp_ready)
                last_grant_q <= id_q;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_co    = rsp_co_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: transaction-level reference model plus directed scenarios.
module tb_alu_req_arbiter;

    logic       clk;
    logic       rst;
    logic       s0_valid, s1_valid;
    logic       s0_ready, s1_ready;
    logic [3:0] s0_a, s0_b, s1_a, s1_b;
    logic [2:0] s0_op, s1_op;
    logic [3:0] alu_a, alu_b, alu_c;
    logic [2:0] alu_op;
    logic       alu_co;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_co, rsp_err, busy;
    logic [3:0] rsp_c;

    int checks   = 0;
    int failures = 0;

    alu_req_arbiter #(.W(4), .NUM_OPS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .s0_valid  (s0_valid),
        .s0_ready  (s0_ready),
        .s0_a      (s0_a),
        .s0_b      (s0_b),
        .s0_op     (s0_op),
        .s1_valid  (s1_valid),
        .s1_ready  (s1_ready),
        .s1_a      (s1_a),
        .s1_b      (s1_b),
        .s1_op     (s1_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .alu_co    (alu_co),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .rsp_co    (rsp_co),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: 0 and, 1 add, 2 subtract (carry = no borrow), 3 xor, 4 or.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a & b};
            3'd1:    return {1'b0, a} + {1'b0, b};
            3'd2:    return {1'b0, a} + {1'b0, ~b} + 5'd1;
            3'd3:    return {1'b0, a ^ b};
            3'd4:    return {1'b0, a | b};
            default: return 5'd0;
        endcase
    endfunction

    assign {alu_co, alu_c} = alu_f(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction, tracked as "in flight" and "still to evaluate".
    bit       m_inflight = 0;
    bit       m_exec     = 0;
    bit       m_last     = 1;
    bit       m_id       = 0;
    bit       m_co       = 0;
    bit       m_err      = 0;
    bit [3:0] m_a = 0, m_b = 0, m_c = 0;
    bit [2:0] m_op = 0;

    function automatic bit exp_r0();
        return !rst && !m_inflight && s0_valid && (!s1_valid || m_last);
    endfunction

    function automatic bit exp_r1();
        return !rst && !m_inflight && s1_valid && (!s0_valid || !m_last);
    endfunction

    always @(posedge clk) begin
        bit       take0, take1;
        bit [2:0] op;
        bit [4:0] r;
        take0 = exp_r0();
        take1 = exp_r1();
        if (rst) begin
            m_inflight = 0; m_exec = 0; m_last = 1; m_id = 0;
            m_co = 0; m_err = 0; m_a = 0; m_b = 0; m_c = 0; m_op = 0;
        end else if (!m_inflight) begin
            if (take0 || take1) begin
                op         = take1 ? s1_op : s0_op;
                m_id       = take1;
                m_inflight = 1;
                if (op < 3'd5) begin
                    m_a    = take1 ? s1_a : s0_a;
                    m_b    = take1 ? s1_b : s0_b;
                    m_op   = op;
                    m_exec = 1;
                end else begin
                    m_err  = 1; m_c = 0; m_co = 0; m_exec = 0;
                end
            end
        end else if (m_exec) begin
            r      = alu_f(m_a, m_b, m_op);
            m_co   = r[4];
            m_c    = r[3:0];
            m_err  = 0;
            m_exec = 0;
        end else if (rsp_ready) begin
            m_inflight = 0;
            m_last     = m_id;
        end
    end

    always @(negedge clk) begin
        chk("s0_ready",  int'(s0_ready),  int'(exp_r0()));
        chk("s1_ready",  int'(s1_ready),  int'(exp_r1()));
        chk("alu_a",     int'(alu_a),     int'(m_a));
        chk("alu_b",     int'(alu_b),     int'(m_b));
        chk("alu_op",    int'(alu_op),    int'(m_op));
        chk("alu_op_ok", int'(alu_op < 3'd5), 1);
        chk("rsp_valid", int'(rsp_valid), int'(m_inflight && !m_exec));
        chk("busy",      int'(busy),      int'(m_inflight));
        chk("rsp_id",    int'(rsp_id),    int'(m_id));
        chk("rsp_c",     int'(rsp_c),     int'(m_c));
        chk("rsp_co",    int'(rsp_co),    int'(m_co));
        chk("rsp_err",   int'(rsp_err),   int'(m_err));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (!busy) break;
            cyc();
        end
        chk("drain_idle", int'(busy), 0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int       grants[$];
        int       ids[$];
        bit [3:0] snap_c;
        bit       snap_id, snap_co, snap_err;

        rst = 1'b1; rsp_ready = 1'b0;
        s0_valid = 1'b1; s0_a = 4'd3; s0_b = 4'd1; s0_op = 3'd1;
        s1_valid = 1'b0; s1_a = 4'd0; s1_b = 4'd0; s1_op = 3'd0;

        cyc(); smp();
        chk("rst_s0_ready",  int'(s0_ready),  0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_alu_a",     int'(alu_a),     0);
        chk("rst_rsp_id",    int'(rsp_id),    0);
        cyc(); rst = 1'b0; s0_valid = 1'b0;

        // Single legal request from s0.
        cyc(); s0_valid = 1'b1; s0_a = 4'b1110; s0_b = 4'b1010; s0_op = 3'b001;
        smp();
        chk("t1_s0_ready", int'(s0_ready), 1);
        chk("t1_s1_ready", int'(s1_ready), 0);
        cyc(); s0_valid = 1'b0;
        smp();
        chk("t1_alu_a",       int'(alu_a),     4'b1110);
        chk("t1_alu_op",      int'(alu_op),    1);
        chk("t1_no_rsp_exec", int'(rsp_valid), 0);
        cyc(); rsp_ready = 1'b1;
        smp();
        chk("t1_rsp_valid", int'(rsp_valid), 1);
        chk("t1_rsp_id",    int'(rsp_id),    0);
        chk("t1_rsp_c",     int'(rsp_c),     4'b1000);
        chk("t1_rsp_co",    int'(rsp_co),    1);
        chk("t1_rsp_err",   int'(rsp_err),   0);
        cyc(); rsp_ready = 1'b0;
        smp();
        chk("t1_idle", int'(busy), 0);

        // Continuous tie after reset: grants alternate starting with s0.
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; rsp_ready = 1'b1;
        s0_valid = 1'b1; s0_a = 4'd3; s0_b = 4'd4; s0_op = 3'd1;
        s1_valid = 1'b1; s1_a = 4'd9; s1_b = 4'd2; s1_op = 3'd2;
        for (int i = 0; i < 13; i++) begin
            smp();
            if (s0_ready) grants.push_back(0);
            if (s1_ready) grants.push_back(1);
            if (rsp_valid && rsp_ready) ids.push_back(int'(rsp_id));
            cyc();
        end
        chk("tie_grant_count", int'(grants.size() >= 4), 1);
        chk("tie_id_count",    int'(ids.size() >= 4),    1);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("tie_grant", grants[i], i % 2);
        for (int i = 0; i < 4 && i < ids.size(); i++)    chk("tie_rsp_id", ids[i], i % 2);
        s0_valid = 1'b0; s1_valid = 1'b0;
        drain();

        // Illegal opcode from s1 skips evaluation.
        cyc(); s1_valid = 1'b1; s1_a = 4'd5; s1_b = 4'd7; s1_op = 3'b110;
        smp();
        chk("ill_s1_ready", int'(s1_ready), 1);
        cyc(); s1_valid = 1'b0;
        smp();
        chk("ill_rsp_valid", int'(rsp_valid), 1);
        chk("ill_rsp_err",   int'(rsp_err),   1);
        chk("ill_rsp_c",     int'(rsp_c),     0);
        chk("ill_rsp_co",    int'(rsp_co),    0);
        chk("ill_rsp_id",    int'(rsp_id),    1);
        drain();

        // Backpressure: response held while both requesters wait.
        cyc();
        s0_valid = 1'b1; s0_a = 4'd9; s0_b = 4'd3; s0_op = 3'd2;
        s1_valid = 1'b1; s1_a = 4'd1; s1_b = 4'd2; s1_op = 3'd1;
        smp();
        chk("bp_s0_first", int'(s0_ready), 1);
        cyc(); smp();
        chk("bp_exec_no_ready", int'(s0_ready || s1_ready), 0);
        cyc(); smp();
        chk("bp_rsp_valid", int'(rsp_valid), 1);
        chk("bp_rsp_c",     int'(rsp_c),     6);
        chk("bp_rsp_co",    int'(rsp_co),    1);
        chk("bp_rsp_id",    int'(rsp_id),    0);
        snap_c = rsp_c; snap_id = rsp_id; snap_co = rsp_co; snap_err = rsp_err;
        for (int i = 0; i < 4; i++) begin
            cyc(); smp();
            chk("bp_hold_valid", int'(rsp_valid), 1);
            chk("bp_hold_c",     int'(rsp_c),     int'(snap_c));
            chk("bp_hold_id",    int'(rsp_id),    int'(snap_id));
            chk("bp_hold_co",    int'(rsp_co),    int'(snap_co));
            chk("bp_hold_err",   int'(rsp_err),   int'(snap_err));
            chk("bp_no_ready",   int'(s0_ready || s1_ready), 0);
        end
        cyc(); rsp_ready = 1'b1;
        smp();
        chk("bp_release_valid", int'(rsp_valid), 1);
        cyc(); rsp_ready = 1'b0;
        smp();
        chk("bp_next_s1", int'(s1_ready), 1);
        cyc(); s0_valid = 1'b0; s1_valid = 1'b0;
        drain();

        // Reset while evaluating drops the request and restores the tie priority.
        cyc(); s0_valid = 1'b1; s0_a = 4'd1; s0_b = 4'd1; s0_op = 3'd1;
        smp();
        chk("rx_accept", int'(s0_ready), 1);
        cyc(); s0_valid = 1'b0; rst = 1'b1;
        smp();
        chk("rx_in_exec", int'(busy), 1);
        cyc(); rst = 1'b0; s0_valid = 1'b1; s1_valid = 1'b1;
        smp();
        chk("rx_rsp_valid", int'(rsp_valid), 0);
        chk("rx_busy",      int'(busy),      0);
        chk("rx_tie_s0",    int'(s0_ready),  1);
        chk("rx_tie_s1",    int'(s1_ready),  0);
        cyc(); s0_valid = 1'b0; s1_valid = 1'b0;
        drain();

        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
